ps2_key_rx: RTL and testbench
=============================

PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 3000: clk_sys cycles without a falling ps2_clk edge that abort a partial frame.
REQ-002 SHALL have parameter FILTER_LEN, default 4: number of consecutive equal samples required before the filtered ps2_clk changes.
REQ-003 clk_sys  input  1  system clock; all state on rising edge.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk_sys.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous to clk_sys.
REQ-007 ps2_key  output  65  key event: [63:0] byte history, newest byte in [7:0]; [64] toggles once per completed event.
REQ-008 byte_strobe  output  1  one-cycle pulse per accepted byte.
REQ-009 frame_err  output  1  one-cycle pulse per aborted or rejected frame.

Function
REQ-010 ps2_clk and ps2_data SHALL pass through a 2-flop synchronizer; ps2_clk SHALL additionally pass the FILTER_LEN stability filter.
REQ-011 A falling edge of the filtered clock SHALL sample synchronized ps2_data.
REQ-012 Frame FSM states IDLE, DATA, PARITY, STOP, in that order.
REQ-013 IDLE -> DATA on a falling edge sampling 0; a falling edge sampling 1 SHALL stay in IDLE with no error.
REQ-014 DATA SHALL shift 8 bits LSB first, then go to PARITY; PARITY SHALL go to STOP.
REQ-015 In STOP, sampled 1 SHALL accept the byte; sampled 0 SHALL pulse frame_err and discard the byte. Both SHALL return to IDLE.
REQ-016 A byte is accepted the cycle after the stop-bit edge; byte_strobe SHALL pulse in that cycle.
REQ-017 A watchdog SHALL count cycles since the last falling edge while not in IDLE; at TIMEOUT it SHALL pulse frame_err, return to IDLE and clear the sequence.
REQ-018 Each accepted byte SHALL shift into an internal 64-bit sequence register (seq <= {seq[55:0], byte}).
REQ-019 Prefix bytes E0 and F0 SHALL NOT complete an event.
REQ-020 Byte E1 SHALL start a fixed 8-byte sequence; the 8th byte completes the event whatever its value.
REQ-021 A terminal byte SHALL be held, not completing, when it is 12 directly after E0, or 7C directly after E0 F0; the next terminal byte completes the event.
REQ-022 Any other byte SHALL complete the event.
REQ-023 On completion, ps2_key[63:0] SHALL load the full sequence, zero-extended above its oldest byte.
REQ-024 On completion, ps2_key[64] SHALL toggle in the same cycle; the sequence register SHALL then clear.
REQ-025 A sequence longer than 8 bytes SHALL keep only the newest 8 bytes.
REQ-026 ps2_key SHALL be unchanged between completions.
REQ-027 A frame error SHALL clear the sequence but SHALL NOT change ps2_key.
REQ-028 A completion coinciding with a watchdog expiry SHALL be impossible by construction: the watchdog is inactive in IDLE.

Reset
REQ-029 While reset_n is low: FSM SHALL be IDLE and all counters, synchronizers and the sequence register zero.
REQ-030 While reset_n is low: ps2_key = 0, byte_strobe = 0, frame_err = 0.
REQ-031 Deasserting reset_n mid-frame SHALL resume in IDLE; bits already on the line SHALL be ignored until a start bit is seen.

Configuration
REQ-032 With PS2_KEY_RX_PARITY_EN defined: a byte whose 9 data+parity bits have an even count of ones SHALL be rejected.
REQ-033 A rejected byte SHALL pulse frame_err at the stop bit, be discarded, and clear the sequence.
REQ-034 Without PS2_KEY_RX_PARITY_EN the parity bit SHALL be sampled and ignored.

Verification
REQ-035 Frame 1C, correct parity -> byte_strobe once; ps2_key[63:0] = 0x1C; bit 64 toggles 0->1.
REQ-036 Frames F0, 1C -> a single toggle; ps2_key[63:0] = 0xF01C.
REQ-037 Frames E0 12 E0 7C -> a single toggle; ps2_key[63:0] = 0xE012E07C.
REQ-038 Pause, E1 14 77 E1 F0 14 F0 77 -> a single toggle; ps2_key[63:0] = 0xE11477E1F014F077.
REQ-039 Frame stopped after 4 data bits, then TIMEOUT cycles idle -> frame_err pulse; ps2_key unchanged; a following 75 frame gives ps2_key[63:0] = 0x75.
REQ-040 With PS2_KEY_RX_PARITY_EN defined, 1C sent with wrong parity -> frame_err, no toggle. Without the macro -> 0x1C accepted.

Source files
------------

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the raw lines, frames bytes
// and assembles multi-byte key events. Define PS2_KEY_RX_PARITY_EN to reject bad-parity bytes.
module ps2_key_rx #(
  parameter int TIMEOUT    = 3000,
  parameter int FILTER_LEN = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [64:0] ps2_key,
  output logic        byte_strobe,
  output logic        frame_err
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int FW  = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]     clk_sync, dat_sync;
  logic           clk_filt, clk_filt_d;
  logic [FW-1:0]  filt_cnt;
  logic           fall, din;

  state_t         state;
  logic [7:0]     shreg;
  logic [2:0]     bit_cnt;
  logic [WDW-1:0] wd_cnt;
  logic           wd_exp, par_ok, accept, err_now;

  logic [63:0]    seq, seq_next;
  logic [2:0]     e1_cnt;
  logic           done;

  // filtered clock only moves after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync   <= '0;
      dat_sync   <= '0;
      clk_filt   <= 1'b0;
      clk_filt_d <= 1'b0;
      filt_cnt   <= '0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      dat_sync   <= {dat_sync[0], ps2_data};
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall   = clk_filt_d & ~clk_filt;
  assign din    = dat_sync[1];
  assign wd_exp = (state != IDLE) && !fall && (wd_cnt == WDW'(TIMEOUT - 1));

`ifdef PS2_KEY_RX_PARITY_EN
  logic par_bit;
  assign par_ok = ^{par_bit, shreg};
`else
  assign par_ok = 1'b1;
`endif

  assign accept  = fall && (state == STOP) && din && par_ok;
  assign err_now = wd_exp || (fall && (state == STOP) && !(din && par_ok));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      wd_cnt      <= '0;
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
`ifdef PS2_KEY_RX_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      byte_strobe <= accept;
      frame_err   <= err_now;
      wd_cnt      <= (state == IDLE || fall) ? '0 : wd_cnt + 1'b1;
      if (wd_exp) begin
        state <= IDLE;
      end else if (fall) begin
        case (state)
          IDLE: if (!din) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
`ifdef PS2_KEY_RX_PARITY_EN
            par_bit <= din;
`endif
            state <= STOP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign seq_next = {seq[55:0], shreg};

  // E1 runs are counted blindly; E0/F0 prefixes and the 12 / 7C fillers are held
  always_comb begin
    done = 1'b1;
    if (e1_cnt != 3'd0)
      done = (e1_cnt == 3'd7);
    else if (shreg == 8'hE1 || shreg == 8'hE0 || shreg == 8'hF0)
      done = 1'b0;
    else if (shreg == 8'h12 && seq[7:0] == 8'hE0)
      done = 1'b0;
    else if (shreg == 8'h7C && seq[15:0] == 16'hE0F0)
      done = 1'b0;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      seq     <= '0;
      e1_cnt  <= '0;
      ps2_key <= '0;
    end else if (err_now) begin
      seq    <= '0;
      e1_cnt <= '0;
    end else if (accept) begin
      if (done) begin
        ps2_key <= {~ps2_key[64], seq_next};
        seq     <= '0;
        e1_cnt  <= '0;
      end else begin
        seq <= seq_next;
        if (e1_cnt != 3'd0)       e1_cnt <= e1_cnt + 1'b1;
        else if (shreg == 8'hE1)  e1_cnt <= 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: random key events built from byte-group rules,
// expected ps2_key values queued at issue time and popped by a monitor on each toggle.
module tb_ps2_key_rx;
  localparam int TMO  = 400;
  localparam int FL   = 4;
  localparam int HALF = 12;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [64:0] ps2_key;
  logic        byte_strobe, frame_err;

  ps2_key_rx #(.TIMEOUT(TMO), .FILTER_LEN(FL)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_key(ps2_key), .byte_strobe(byte_strobe), .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0, n_bad = 0;
  int n_strb = 0, n_ferr = 0, exp_strb = 0, exp_ferr = 0;
  logic [64:0] exp_q[$];
  logic        exp_tog = 1'b0;
  logic [7:0]  ev[$];
  logic [64:0] last_key = '0;
  logic        mon_en = 1'b0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // one PS/2 bit; optional 1-cycle clock glitch that the filter must reject
  task automatic ps2_bit(input logic d, input bit glitch);
    ps2_data = d;
    if (glitch) begin
      cyc(3); ps2_clk = 1'b0; cyc(1); ps2_clk = 1'b1; cyc(HALF - 4);
    end else begin
      cyc(HALF);
    end
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par, input int nbits);
    logic [10:0] fr;
    fr = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i], $urandom_range(0, 3) == 0);
    ps2_data = 1'b1;
    cyc($urandom_range(20, 60));
  endtask

  // reference: an event's key is its bytes packed oldest-first, newest 8 kept
  task automatic send_event(input logic bad_par);
    logic [63:0] val;
    val = '0;
    foreach (ev[i]) val = {val[55:0], ev[i]};
    exp_tog = ~exp_tog;
    exp_q.push_back({exp_tog, val});
    exp_strb += ev.size();
    foreach (ev[i]) send_frame(ev[i], 1'b1, bad_par, 11);
    ev.delete();
  endtask

  function automatic logic [7:0] rnd_excl(input logic [7:0] x);
    logic [7:0] b;
    do b = 8'($urandom);
    while (b == 8'hE0 || b == 8'hF0 || b == 8'hE1 || b == x);
    return b;
  endfunction

  always @(negedge clk_sys) begin
    if (mon_en) begin
      if (byte_strobe) n_strb++;
      if (frame_err)   n_ferr++;
      if (ps2_key[64] != last_key[64]) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_event: got %h want none", ps2_key);
        end else begin
          check("event", ps2_key, exp_q.pop_front());
        end
      end else if (ps2_key != last_key) begin
        check("key_stable", ps2_key, last_key);
      end
      last_key = ps2_key;
    end
  end

  initial begin
    cyc(4);
    check("rst_key", ps2_key, 65'h0);
    check("rst_strobe", {64'h0, byte_strobe}, 65'h0);
    check("rst_err", {64'h0, frame_err}, 65'h0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    cyc(20);

    ev = '{8'h1C}; send_event(1'b0);
    ev = '{8'hF0, 8'h1C}; send_event(1'b0);
    ev = '{8'hE0, 8'h12, 8'hE0, 8'h7C}; send_event(1'b0);
    cyc(200);
    ev = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77}; send_event(1'b0);
    ev = '{8'hE0, 8'hF0, 8'h7C, 8'hE0, 8'hF0, 8'h12}; send_event(1'b0);
    // held-filler chain longer than 8 bytes keeps only the newest 8
    ev = '{8'hE0, 8'h12, 8'hE0, 8'h12, 8'hE0, 8'h12, 8'hE0, 8'h12, 8'hE0, 8'h7C};
    send_event(1'b0);

    // truncated frame aborted by the watchdog
    send_frame(8'h55, 1'b1, 1'b0, 5);
    cyc(TMO + 50);
    exp_ferr++;
    ev = '{8'h75}; send_event(1'b0);

    // bad stop bit discards the byte and the pending F0 prefix
    send_frame(8'hF0, 1'b1, 1'b0, 11); exp_strb++;
    send_frame(8'h1C, 1'b0, 1'b0, 11); exp_ferr++;
    ev = '{8'h1C}; send_event(1'b0);

    // watchdog mid-sequence also drops the prefix
    send_frame(8'hE0, 1'b1, 1'b0, 11); exp_strb++;
    send_frame(8'h33, 1'b1, 1'b0, 7);
    cyc(TMO + 50);
    exp_ferr++;
    ev = '{8'h12}; send_event(1'b0);

`ifdef PS2_KEY_RX_PARITY_EN
    send_frame(8'h1C, 1'b1, 1'b1, 11); exp_ferr++;
`else
    ev = '{8'h1C}; send_event(1'b1);
`endif

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 5))
        0: ev = '{rnd_excl(8'hE0)};
        1: ev = '{8'hF0, rnd_excl(8'hE0)};
        2: ev = '{8'hE0, rnd_excl(8'h12)};
        3: ev = '{8'hE0, 8'hF0, rnd_excl(8'h7C)};
        4: ev = '{8'hE0, 8'h12, 8'hE0, rnd_excl(8'h12)};
        default: begin
          ev = '{8'hE1};
          for (int k = 0; k < 7; k++) ev.push_back(8'($urandom));
        end
      endcase
      send_event(1'b0);
    end

    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) cyc(1);
    cyc(10);
    check("pending_events", 65'(exp_q.size()), 65'h0);
    check("strobe_count", 65'(n_strb), 65'(exp_strb));
    check("frame_err_count", 65'(n_ferr), 65'(exp_ferr));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
